imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. Accepts a full 32-bit instruction word over a valid/ready handshake, builds the sign-extended I/S/B/U/J immediate at XLEN bits, and presents it with a pass-through tag through a two-entry elastic buffer. This supersedes the combinational 32-bit extender: U-type is added, and illegal selections are flagged. The buffer lets the extender sit between fetch and register read without stalling on single-cycle backpressure.

## Interface
- XLEN, 32: output immediate width; legal values 32 or 64.
- TAGW, 5: width of the tag carried alongside each instruction (e.g. rd or ROB index); minimum 1.
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction word present.
- in_ready  out  1  block can accept this cycle.
- instr  in  32  instruction word; immediate fields at their RV32 positions.
- src  in  3  type select: 000 I, 001 S, 010 B, 011 U, 100 J, 101–111 illegal.
- tag_in  in  TAGW  opaque tag.
- out_valid  out  1  inmExt/tag_out/err valid.
- out_ready  in  1  consumer accepts.
- inmExt  out  XLEN  extended immediate.
- tag_out  out  TAGW  tag matching inmExt.
- err  out  1  entry had an illegal type; inmExt is 0 for that entry.

## Operation
- Immediates (s = sign-extend to XLEN from the top bit shown):
  - I: s(instr[31:20]).
  - S: s({instr[31:25], instr[11:7]}).
  - B: s({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: s({instr[31:12], 12'b0}); with XLEN=64, bits 63:32 copy instr[31].
  - J: s({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Illegal: inmExt = 0, err = 1.
- The immediate is computed combinationally on the input side and captured on the accepted edge; no arithmetic is performed beyond concatenation.
- Buffer: output register (OR) plus one skid entry (SK). States:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: OR valid, in_ready=1. Accept & out_ready -> ONE (OR reloaded). Accept & !out_ready -> FULL (into SK). !accept & out_ready -> EMPTY.
  - FULL: OR and SK valid, in_ready=0. out_ready -> ONE (SK moves into OR on the same edge). in_valid is ignored.
- in_ready depends only on state (registered), never on out_ready combinationally.
- Entries leave in acceptance order; tag_out and err always travel with their inmExt.
- Outputs hold stable while out_valid=1 and out_ready=0.

## Timing
- Latency: accepted on edge N -> out_valid=1 with result after edge N.
- Throughput: one per cycle while out_ready=1.
- Reset (async assert, sync-safe deassert by system): state EMPTY, out_valid=0, in_ready=1, inmExt=0, tag_out=0, err=0. Assertion mid-transfer discards OR and SK contents immediately.
- Simultaneous accept and drain in ONE: no bubble, and the new entry appears after the same edge.
- Simultaneous accept and drain in FULL is impossible (in_ready=0).

## Configuration
- IMM_AUTODEC_EN defined: src is ignored; type is decoded from instr[6:0]. 0010011/0000011/1100111/1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; any other opcode -> illegal (err=1, inmExt=0).
- Not defined: type comes from src only; the opcode bits are don't-care.

## Test plan
- XLEN=32, src=000, instr=0xFFF00093, out_ready=1 -> one cycle later out_valid=1, inmExt=0xFFFFFFFF, err=0.
- Back-to-back: S 0xFE112E23, then J 0xFFDFF06F, then B 0xFE000EE3 -> consecutive outputs 0xFFFFFFFC, 0xFFFFFFFC, 0xFFFFFFFC, with tags in order and no bubbles.
- XLEN=64, src=011, instr=0x800000B7 -> inmExt=0xFFFFFFFF80000000; src=110 -> inmExt=0 and err=1.
- Backpressure: hold out_ready=0 and present 3 words with tags 1,2,3 -> tags 1 and 2 accepted, in_ready=0 after the second accept, outputs stable; release -> tags 1,2 drain, then 3 is accepted.
- Reset while FULL: drop rst_n asynchronously mid-cycle -> out_valid=0, in_ready=1, inmExt=0 without waiting for a clock edge; no stale entry appears after release.
- IMM_AUTODEC_EN defined: instr=0x0000006F with src=000 -> decoded as J, inmExt=0; instr=0x0000007F -> err=1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered I/S/B/U/J immediate generator behind a two-entry elastic buffer (optional IMM_AUTODEC_EN: decode type from opcode)
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      src,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] inmExt,
  output logic [TAGW-1:0] tag_out,
  output logic            err
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] or_imm_q, or_imm_d, sk_imm_q, sk_imm_d;
  logic [TAGW-1:0] or_tag_q, or_tag_d, sk_tag_q, sk_tag_d;
  logic            or_err_q, or_err_d, sk_err_q, sk_err_d;
  logic [2:0]      sel;
  logic [31:0]     imm32;
  logic            bad;
  logic [XLEN-1:0] imm_x;
  logic            accept, load_or, load_sk;
`ifdef IMM_AUTODEC_EN
  logic unused_src;
  assign unused_src = ^src;
  // Map the opcode onto the same type codes that src uses
  always_comb begin
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: sel = 3'd0;
      7'b0100011: sel = 3'd1;
      7'b1100011: sel = 3'd2;
      7'b0110111, 7'b0010111: sel = 3'd3;
      7'b1101111: sel = 3'd4;
      default: sel = 3'd7;
    endcase
  end
`else
  logic unused_opc;
  assign unused_opc = ^instr[6:0];
  assign sel = src;
`endif
  // Build the 32-bit immediate by field concatenation; illegal selections give zero
  always_comb begin
    imm32 = '0;
    bad   = 1'b0;
    case (sel)
      3'd0: imm32 = {{20{instr[31]}}, instr[31:20]};
      3'd1: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'd2: imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      3'd3: imm32 = {instr[31:12], 12'b0};
      3'd4: imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: bad = 1'b1;
    endcase
  end
  assign imm_x  = XLEN'($signed(imm32));
  assign accept = in_valid & in_ready;
  // Buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end
  // Buffer next state
  always_comb begin
    case (state_q)
      EMPTY:   state_d = accept ? ONE : EMPTY;
      ONE:     state_d = accept ? (out_ready ? ONE : FULL) : (out_ready ? EMPTY : ONE);
      FULL:    state_d = out_ready ? ONE : FULL;
      default: state_d = EMPTY;
    endcase
  end
  // Handshake outputs depend on state only
  always_comb begin
    out_valid = state_q != EMPTY;
    in_ready  = state_q != FULL;
  end
  // OR reloads from the input, or from SK when draining a full buffer; SK fills only on a stalled accept
  always_comb begin
    load_or  = (state_q == EMPTY && accept) || (state_q == ONE && accept && out_ready) ||
               (state_q == FULL && out_ready);
    load_sk  = state_q == ONE && accept && !out_ready;
    or_imm_d = load_or ? (state_q == FULL ? sk_imm_q : imm_x) : or_imm_q;
    or_tag_d = load_or ? (state_q == FULL ? sk_tag_q : tag_in) : or_tag_q;
    or_err_d = load_or ? (state_q == FULL ? sk_err_q : bad) : or_err_q;
    sk_imm_d = load_sk ? imm_x : sk_imm_q;
    sk_tag_d = load_sk ? tag_in : sk_tag_q;
    sk_err_d = load_sk ? bad : sk_err_q;
  end
  // Entry storage, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_imm_q <= '0;
      or_tag_q <= '0;
      or_err_q <= 1'b0;
      sk_imm_q <= '0;
      sk_tag_q <= '0;
      sk_err_q <= 1'b0;
    end else begin
      or_imm_q <= or_imm_d;
      or_tag_q <= or_tag_d;
      or_err_q <= or_err_d;
      sk_imm_q <= sk_imm_d;
      sk_tag_q <= sk_tag_d;
      sk_err_q <= sk_err_d;
    end
  end
  assign inmExt  = or_imm_q;
  assign tag_out = or_tag_q;
  assign err     = or_err_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe at XLEN=32 and XLEN=64
module tb_imm_gen_pipe;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [31:0] instr = 0;
  logic [2:0]  src = 0;
  logic [4:0]  tag_in = 0;
  logic        in_ready, out_valid, err, in_ready64, out_valid64, err64;
  logic [4:0]  tag_out, tag_out64;
  logic [31:0] inmExt;
  logic [63:0] inmExt64;
  typedef struct {logic [63:0] imm; logic [4:0] tag; logic e;} exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  bit   rnd_ready = 0;
  imm_gen_pipe #(.XLEN(32), .TAGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .src(src), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .inmExt(inmExt), .tag_out(tag_out), .err(err));
  imm_gen_pipe #(.XLEN(64), .TAGW(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64), .instr(instr),
    .src(src), .tag_in(tag_in), .out_valid(out_valid64), .out_ready(out_ready),
    .inmExt(inmExt64), .tag_out(tag_out64), .err(err64));
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s, output logic e);
    longint x = longint'($signed(w));
    int t;
`ifdef IMM_AUTODEC_EN
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: t = 0;
      7'h23: t = 1;
      7'h63: t = 2;
      7'h37, 7'h17: t = 3;
      7'h6F: t = 4;
      default: t = 7;
    endcase
`else
    t = int'(s);
`endif
    e = 0;
    case (t)
      0: return x >>> 20;
      1: return ((x >>> 25) << 5) | longint'(w[11:7]);
      2: return ((x >>> 31) << 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
      3: return x & -64'sd4096;
      4: return ((x >>> 31) << 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
      default: begin e = 1; return 0; end
    endcase
  endfunction
  bit          hold = 0;
  logic [63:0] h_imm;
  logic [4:0]  h_tag;
  logic        h_err;
  always @(negedge clk) begin
    exp_t x;
    logic e;
    if (!rst_n) begin
      sb.delete();
      hold = 0;
    end else begin
      if (in_valid && in_ready) begin
        x.imm = ref_imm(instr, src, e);
        x.tag = tag_in;
        x.e   = e;
        sb.push_back(x);
      end
      chk("valid64", {63'b0, out_valid64}, {63'b0, out_valid});
      chk("ready64", {63'b0, in_ready64}, {63'b0, in_ready});
      if (hold && out_valid) begin
        chk("stable_imm", inmExt64, h_imm);
        chk("stable_tag", {59'b0, tag_out}, {59'b0, h_tag});
        chk("stable_err", {63'b0, err}, {63'b0, h_err});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_pop: output tag %0d with no expected entry", tag_out);
        end else begin
          x = sb.pop_front();
          chk("imm32", {32'b0, inmExt}, {32'b0, x.imm[31:0]});
          chk("imm64", inmExt64, x.imm);
          chk("tag", {59'b0, tag_out}, {59'b0, x.tag});
          chk("tag64", {59'b0, tag_out64}, {59'b0, x.tag});
          chk("err", {63'b0, err}, {63'b0, x.e});
          chk("err64", {63'b0, err64}, {63'b0, x.e});
        end
      end
      hold  = out_valid && !out_ready;
      h_imm = inmExt64;
      h_tag = tag_out;
      h_err = err;
    end
  end
  always @(posedge clk) if (rnd_ready) #1 out_ready = 1'($urandom % 2);
  task automatic send(input logic [31:0] w, input logic [2:0] s, input logic [4:0] t);
    int n = 0;
    instr = w; src = s; tag_in = t; in_valid = 1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n >= 100) begin
        n_chk++;
        $display("FAIL send_timeout: tag %0d never accepted", t);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d entries left", sb.size());
    end
  endtask
  task automatic chk_reset_outs(string nm);
    chk({nm, "_valid"}, {63'b0, out_valid}, 64'd0);
    chk({nm, "_ready"}, {63'b0, in_ready}, 64'd1);
    chk({nm, "_imm"}, {32'b0, inmExt}, 64'd0);
    chk({nm, "_imm64"}, inmExt64, 64'd0);
    chk({nm, "_tag"}, {59'b0, tag_out}, 64'd0);
    chk({nm, "_err"}, {63'b0, err}, 64'd0);
  endtask
  initial begin
    #12;
    chk_reset_outs("rst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    out_ready = 1;
    send(32'hFFF00093, 3'b000, 5'd1);
    chk("lat_valid", {63'b0, out_valid}, 64'd1);
    chk("lat_imm", {32'b0, inmExt}, 64'hFFFFFFFF);
    chk("lat_err", {63'b0, err}, 64'd0);
    send(32'hFE112E23, 3'b001, 5'd2);
    chk("s_imm", {32'b0, inmExt}, 64'hFFFFFFFC);
    send(32'hFFDFF06F, 3'b100, 5'd3);
    chk("j_imm", {32'b0, inmExt}, 64'hFFFFFFFC);
    chk("j_valid", {63'b0, out_valid}, 64'd1);
    send(32'hFE000EE3, 3'b010, 5'd4);
    chk("b_imm", {32'b0, inmExt}, 64'hFFFFFFFC);
    chk("b_tag", {59'b0, tag_out}, 64'd4);
    send(32'h800000B7, 3'b011, 5'd5);
    chk("u_imm64", inmExt64, 64'hFFFFFFFF80000000);
    chk("u_imm32", {32'b0, inmExt}, 64'h80000000);
    send(32'h12345678, 3'b110, 5'd6);
    chk("ill_err", {63'b0, err64}, 64'd1);
    chk("ill_imm", inmExt64, 64'd0);
    wait_drain();
    out_ready = 0;
    send($urandom, 3'b000, 5'd1);
    send($urandom, 3'b001, 5'd2);
    chk("bp_ready", {63'b0, in_ready}, 64'd0);
    instr = 32'h00500093; src = 3'b000; tag_in = 5'd3; in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_ready", {63'b0, in_ready}, 64'd0);
      chk("bp_hold_tag", {59'b0, tag_out}, 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1;
    send(32'h00500093, 3'b000, 5'd3);
    wait_drain();
    out_ready = 0;
    send($urandom, 3'b011, 5'd7);
    send($urandom, 3'b100, 5'd8);
    chk("full_valid", {63'b0, out_valid}, 64'd1);
    chk("full_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #3 rst_n = 0;
    #1 chk_reset_outs("arst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    out_ready = 1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_valid", {63'b0, out_valid}, 64'd0);
    end
`ifdef IMM_AUTODEC_EN
    @(posedge clk); #1;
    send(32'h0000006F, 3'b000, 5'd9);
    chk("ad_j_imm", inmExt64, 64'd0);
    chk("ad_j_err", {63'b0, err}, 64'd0);
    send(32'h0000007F, 3'b000, 5'd10);
    chk("ad_ill_err", {63'b0, err}, 64'd1);
    wait_drain();
`endif
    @(posedge clk); #1;
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) begin
        @(posedge clk); #1;
      end else send($urandom, 3'($urandom % 8), 5'($urandom));
    end
    rnd_ready = 0;
    @(posedge clk); #2;
    out_ready = 1;
    wait_drain();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
